// File: rtl/game_pkg.sv
// Shared game-flow types and the game_active codes used by the screen, HUD
// and sprite blocks.
package game_pkg;

  typedef enum logic [2:0] {
    MENU,
    COUNTDOWN,
    PLAY,
    END_DELAY,
    OVER
  } game_state_t;

  localparam logic [1:0] GAME_MENU = 2'd0;
  localparam logic [1:0] GAME_PLAY = 2'd1;
  localparam logic [1:0] GAME_OVER = 2'd2;

  // Digit shown on screen for the frames remaining in the countdown.
  function automatic logic [1:0] countdown_digit(input int unsigned frames_left,
                                                 input int unsigned step);
    if (frames_left > 2 * step) begin
      return 2'd3;
    end else if (frames_left > step) begin
      return 2'd2;
    end else begin
      return 2'd1;
    end
  endfunction

  // game_active code presented for each controller state.
  function automatic logic [1:0] active_code(input game_state_t state);
    case (state)
      MENU:    return GAME_MENU;
      OVER:    return GAME_OVER;
      default: return GAME_PLAY;
    endcase
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame tick on each rising edge of vblnk; reusable by any block
// that counts in video frames.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vblnk,
  output logic tick
);

  logic vblnk_q;

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbours regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk;
    end
  end

  assign tick = vblnk & ~vblnk_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game-flow controller: menu -> 3-2-1 countdown -> play -> end delay -> game
// over, with all timing counted in frames and every output registered.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_FRAMES = 180,
  parameter int unsigned END_DELAY_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       game_start,
  input  logic       remote_start,
  input  logic       player_2_data_valid,
  input  logic       player_dead,
  input  logic       player_2_dead,
  input  logic       boss_dead,
  output logic [1:0] game_active,
  output logic       game_reset,
  output logic       start_tx,
  output logic       input_freeze,
  output logic [1:0] countdown_val,
  output logic       win
);

  localparam int unsigned CNT_MAX = (COUNTDOWN_FRAMES > END_DELAY_FRAMES) ?
                                    COUNTDOWN_FRAMES : END_DELAY_FRAMES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STEP    = COUNTDOWN_FRAMES / 3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CD_LOAD  = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [CNT_W-1:0] ED_LOAD  = CNT_W'(END_DELAY_FRAMES);

  game_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_q, win_d;
  logic             game_reset_q, game_reset_d;
  logic             start_tx_q, start_tx_d;
  logic [1:0]       game_active_q, game_active_d;
  logic             input_freeze_q, input_freeze_d;
  logic [1:0]       countdown_val_q, countdown_val_d;

  logic tick;
  logic start_ev;
  logic all_players_dead;

  frame_tick_gen u_frame_tick (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .tick  (tick)
  );

  assign start_ev         = game_start | (remote_start & player_2_data_valid);
  // A missing peer cannot keep the game alive, so only the local player counts.
  assign all_players_dead = player_dead & (~player_2_data_valid | player_2_dead);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    win_d        = win_q;
    game_reset_d = 1'b0;
    start_tx_d   = 1'b0;

    case (state_q)
      MENU, OVER: begin
        if (start_ev) begin
          state_d      = COUNTDOWN;
          cnt_d        = CD_LOAD;
          win_d        = 1'b0;
          game_reset_d = 1'b1;
          // A remote-only start is not echoed back to the peer.
          start_tx_d   = game_start;
        end
      end

      COUNTDOWN: begin
        if (tick) begin
          if (cnt_q <= CNT_ONE) begin
            state_d = PLAY;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      PLAY: begin
        if (boss_dead) begin
          state_d = END_DELAY;
          cnt_d   = ED_LOAD;
          win_d   = 1'b1;
        end else if (all_players_dead) begin
          state_d = END_DELAY;
          cnt_d   = ED_LOAD;
          win_d   = 1'b0;
        end
      end

      END_DELAY: begin
        if (tick) begin
          if (cnt_q <= CNT_ONE) begin
            state_d = OVER;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end

      default: begin
        state_d = MENU;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // Outputs follow the next state so they line up with the state register.
    game_active_d   = active_code(state_d);
    input_freeze_d  = (state_d == COUNTDOWN) || (state_d == END_DELAY);
    countdown_val_d = (state_d == COUNTDOWN) ? countdown_digit(32'(cnt_d), STEP) : 2'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= MENU;
      cnt_q           <= CNT_ZERO;
      win_q           <= 1'b0;
      game_reset_q    <= 1'b0;
      start_tx_q      <= 1'b0;
      game_active_q   <= GAME_MENU;
      input_freeze_q  <= 1'b0;
      countdown_val_q <= 2'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      win_q           <= win_d;
      game_reset_q    <= game_reset_d;
      start_tx_q      <= start_tx_d;
      game_active_q   <= game_active_d;
      input_freeze_q  <= input_freeze_d;
      countdown_val_q <= countdown_val_d;
    end
  end

  assign game_active   = game_active_q;
  assign game_reset    = game_reset_q;
  assign start_tx      = start_tx_q;
  assign input_freeze  = input_freeze_q;
  assign countdown_val = countdown_val_q;
  assign win           = win_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios followed by
// randomized stimulus, all compared every cycle against a frame-counting model.
module tb_game_state_ctrl;

  localparam int CD = 6;
  localparam int ED = 4;
  localparam int STEP = CD / 3;

  // Model phases, independent of the RTL encoding.
  localparam int PH_MENU = 10;
  localparam int PH_CD   = 11;
  localparam int PH_PLAY = 12;
  localparam int PH_END  = 13;
  localparam int PH_OVER = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vblnk = 1'b0;
  logic       game_start = 1'b0;
  logic       remote_start = 1'b0;
  logic       player_2_data_valid = 1'b0;
  logic       player_dead = 1'b0;
  logic       player_2_dead = 1'b0;
  logic       boss_dead = 1'b0;
  logic [1:0] game_active;
  logic       game_reset;
  logic       start_tx;
  logic       input_freeze;
  logic [1:0] countdown_val;
  logic       win;

  int checks = 0;
  int failures = 0;

  // Reference model state: phase plus frames elapsed since the phase began.
  int m_phase = PH_MENU;
  int m_elapsed = 0;
  bit m_win = 1'b0;
  bit m_reset_pulse = 1'b0;
  bit m_tx_pulse = 1'b0;
  bit m_prev_vblnk = 1'b0;

  game_state_ctrl #(
    .COUNTDOWN_FRAMES (CD),
    .END_DELAY_FRAMES (ED)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .vblnk               (vblnk),
    .game_start          (game_start),
    .remote_start        (remote_start),
    .player_2_data_valid (player_2_data_valid),
    .player_dead         (player_dead),
    .player_2_dead       (player_2_dead),
    .boss_dead           (boss_dead),
    .game_active         (game_active),
    .game_reset          (game_reset),
    .start_tx            (start_tx),
    .input_freeze        (input_freeze),
    .countdown_val       (countdown_val),
    .win                 (win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase       = PH_MENU;
    m_elapsed     = 0;
    m_win         = 1'b0;
    m_reset_pulse = 1'b0;
    m_tx_pulse    = 1'b0;
    m_prev_vblnk  = 1'b0;
  endtask

  // Called right after each rising edge, with the inputs the DUT just sampled.
  task automatic model_update();
    bit tick;
    bit start;
    if (rst) begin
      model_reset();
      return;
    end
    tick = vblnk && !m_prev_vblnk;
    m_prev_vblnk = vblnk;
    start = game_start || (remote_start && player_2_data_valid);
    m_reset_pulse = 1'b0;
    m_tx_pulse = 1'b0;
    case (m_phase)
      PH_MENU, PH_OVER: if (start) begin
        m_phase = PH_CD;
        m_elapsed = 0;
        m_win = 1'b0;
        m_reset_pulse = 1'b1;
        m_tx_pulse = game_start;
      end
      PH_CD: if (tick) begin
        m_elapsed++;
        if (m_elapsed == CD) m_phase = PH_PLAY;
      end
      PH_PLAY: begin
        if (boss_dead) begin
          m_phase = PH_END; m_elapsed = 0; m_win = 1'b1;
        end else if (player_dead && (!player_2_data_valid || player_2_dead)) begin
          m_phase = PH_END; m_elapsed = 0; m_win = 1'b0;
        end
      end
      PH_END: if (tick) begin
        m_elapsed++;
        if (m_elapsed == ED) m_phase = PH_OVER;
      end
      default: m_phase = PH_MENU;
    endcase
  endtask

  task automatic compare_all();
    int exp_active;
    int exp_digit;
    exp_active = (m_phase == PH_MENU) ? 0 : (m_phase == PH_OVER) ? 2 : 1;
    exp_digit  = (m_phase == PH_CD) ? 3 - m_elapsed / STEP : 0;
    check("game_active", int'(game_active), exp_active);
    check("game_reset", int'(game_reset), int'(m_reset_pulse));
    check("start_tx", int'(start_tx), int'(m_tx_pulse));
    check("input_freeze", int'(input_freeze), int'((m_phase == PH_CD) || (m_phase == PH_END)));
    check("countdown_val", int'(countdown_val), exp_digit);
    check("win", int'(win), int'(m_win));
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs compared there.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic frame();
    vblnk = 1'b1;
    step();
    vblnk = 1'b0;
    step();
    step();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  // Asynchronous reset, asserted mid-cycle and checked before any clock edge.
  task automatic async_reset();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_active", int'(game_active), 0);
    check("rst_async_freeze", int'(input_freeze), 0);
    check("rst_async_win", int'(win), 0);
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_local_start();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
  endtask

  initial begin
    // 1. Reset release with idle inputs.
    #23;
    rst = 1'b0;
    step();
    frames(10);
    check("idle_active", int'(game_active), 0);
    check("idle_reset", int'(game_reset), 0);

    // 2. Local start and full countdown.
    pulse_local_start();
    check("start_active", int'(game_active), 1);
    check("start_reset", int'(game_reset), 1);
    check("start_tx", int'(start_tx), 1);
    check("start_digit", int'(countdown_val), 3);
    step();
    check("start_reset_1cyc", int'(game_reset), 0);
    frames(2);
    check("digit_after2", int'(countdown_val), 2);
    frames(2);
    check("digit_after4", int'(countdown_val), 1);
    frames(2);
    check("play_freeze", int'(input_freeze), 0);
    check("play_digit", int'(countdown_val), 0);

    // 3. Remote start with and without a valid peer.
    async_reset();
    player_2_data_valid = 1'b1;
    remote_start = 1'b1;
    step();
    remote_start = 1'b0;
    check("remote_active", int'(game_active), 1);
    check("remote_reset", int'(game_reset), 1);
    check("remote_no_tx", int'(start_tx), 0);
    async_reset();
    player_2_data_valid = 1'b0;
    remote_start = 1'b1;
    step();
    remote_start = 1'b0;
    check("remote_invalid_menu", int'(game_active), 0);

    // 4. Boss and player die together: boss wins priority.
    pulse_local_start();
    frames(6);
    boss_dead = 1'b1;
    player_dead = 1'b1;
    step();
    boss_dead = 1'b0;
    player_dead = 1'b0;
    check("boss_prio_win", int'(win), 1);
    check("boss_prio_freeze", int'(input_freeze), 1);
    frames(4);
    check("over_active", int'(game_active), 2);
    check("over_win_held", int'(win), 1);

    // 6a. Restart from OVER clears win; start during countdown is ignored.
    pulse_local_start();
    check("restart_reset", int'(game_reset), 1);
    check("restart_win", int'(win), 0);
    step();
    pulse_local_start();
    check("cd_start_ignored", int'(game_reset), 0);
    check("cd_digit_held", int'(countdown_val), 3);

    // 5. Two-player loss needs both players dead.
    player_2_data_valid = 1'b1;
    frames(6);
    player_dead = 1'b1;
    repeat (3) step();
    check("one_dead_play", int'(input_freeze), 0);
    player_2_dead = 1'b1;
    step();
    check("both_dead_freeze", int'(input_freeze), 1);
    check("both_dead_win", int'(win), 0);
    player_dead = 1'b0;
    player_2_dead = 1'b0;

    // 6b. Reset during END_DELAY.
    step();
    async_reset();

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      vblnk = ($urandom_range(0, 3) == 0);
      game_start = ($urandom_range(0, 29) == 0);
      remote_start = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) player_2_data_valid = ~player_2_data_valid;
      player_dead = ($urandom_range(0, 39) == 0);
      player_2_dead = ($urandom_range(0, 2) == 0);
      boss_dead = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level game-flow controller; the consumer of the `game_start` pulse produced by the start/restart button screen.
- Drives the 2-bit `game_active` code (0 menu, 1 playing, 2 game over) back to the screen, sprite and HUD blocks.
- Sequences menu → 3-2-1 countdown → play → end delay → game over, and handles start events from the remote player link.
- All timing is counted in video frames, derived from `vblnk` rising edges.

Parameters:
- COUNTDOWN_FRAMES, 180: frames spent in countdown before play (3 s at 60 Hz); must be a multiple of 3 and ≥3.
- END_DELAY_FRAMES, 120: frames of frozen play after a win/lose event before the game-over screen.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous, active-high reset.
- vblnk  in  1  vertical blank from the timing chain; its rising edge is the frame tick.
- game_start  in  1  one-cycle pulse from the local start/restart button.
- remote_start  in  1  one-cycle pulse: the peer started the game (from the UART link decoder).
- player_2_data_valid  in  1  a peer is connected and its data is valid.
- player_dead  in  1  local player HP is zero (level).
- player_2_dead  in  1  remote player HP is zero (level).
- boss_dead  in  1  boss HP is zero (level).
- game_active  out  2  0 menu, 1 playing (including countdown and end delay), 2 game over.
- game_reset  out  1  one-cycle pulse; entity blocks reinitialise HP and positions.
- start_tx  out  1  one-cycle pulse; request to send a "start" message to the peer.
- input_freeze  out  1  high during countdown and end delay; movement and attack are ignored.
- countdown_val  out  2  3/2/1 during countdown, 0 otherwise.
- win  out  1  1 = boss killed, 0 = players lost; valid in END_DELAY and OVER.

Behaviour:
- All outputs are registered. On reset: state MENU, all outputs 0, counter 0, vblnk history 0.
- Frame tick: `vblnk_q` is a registered copy of `vblnk`; tick = `vblnk & ~vblnk_q`.
- `start_ev` = `game_start | (remote_start & player_2_data_valid)`.
- MENU (`game_active`=0): on `start_ev` → COUNTDOWN and load cnt=COUNTDOWN_FRAMES. In that same update, assert `game_reset`=1 and clear `win`. Assert `start_tx`=1 only if `game_start`=1; a remote-only start does not echo back. Latency: a pulse at edge N gives `game_active`=1 and the pulses visible after edge N+1.
- COUNTDOWN (`game_active`=1, `input_freeze`=1):
  - cnt decrements by 1 on each tick.
  - On a tick with cnt==1: → PLAY, cnt=0.
  - With STEP=COUNTDOWN_FRAMES/3, `countdown_val` is 3 if cnt>2·STEP, 2 if cnt>STEP, else 1.
- PLAY (`game_active`=1, `input_freeze`=0, `countdown_val`=0):
  - `boss_dead` → END_DELAY, `win`=1.
  - Otherwise, if `player_dead` && (!`player_2_data_valid` || `player_2_dead`) → END_DELAY, `win`=0.
  - If `boss_dead` and all-players-dead occur in the same cycle, the boss takes priority: `win`=1.
  - Entering END_DELAY loads cnt=END_DELAY_FRAMES.
- END_DELAY (`game_active`=1, `input_freeze`=1): decrement on tick; on a tick with cnt==1 → OVER.
- OVER (`game_active`=2, `input_freeze`=0): `win` is held. `start_ev` behaves exactly as in MENU, including the `game_reset` and `start_tx` rules.
- `game_start` and `remote_start` are ignored in COUNTDOWN, PLAY and END_DELAY; no pulse outputs are produced.
- `game_reset` and `start_tx` are high for exactly one cycle per accepted start event.
- A tick coinciding with the state entry does not decrement; the counter is loaded on that cycle.
- Counter width is $clog2(max(COUNTDOWN_FRAMES, END_DELAY_FRAMES)+1). Counters never wrap below 0.
- If `player_2_data_valid` drops during PLAY, the loss condition reduces to `player_dead` alone from that cycle.
- Asserting `rst` mid-game immediately forces MENU and zero outputs, independent of `clk`.

Decomposition:
- Package `game_pkg`:
  - `game_state_t` enum {MENU, COUNTDOWN, PLAY, END_DELAY, OVER}.
  - Constants GAME_MENU=2'd0, GAME_PLAY=2'd1, GAME_OVER=2'd2, shared with the screen, HUD and sprite blocks.
- Sub-module `frame_tick_gen`: `vblnk` rising-edge detector producing a one-cycle tick, reusable by animation blocks.
- The FSM and counter stay in `game_state_ctrl`.

Test Plan (bench uses COUNTDOWN_FRAMES=6, END_DELAY_FRAMES=4):
1. Reset release, no stimulus for 10 frames → `game_active`=0, all outputs 0.
2. `game_start` pulse in MENU → next cycle: `game_active`=1, `game_reset`=1 and `start_tx`=1 for one cycle, `countdown_val`=3. After 2 ticks `countdown_val`=2, after 4 ticks 1, after 6 ticks PLAY with `input_freeze`=0.
3. `remote_start` with `player_2_data_valid`=1 → COUNTDOWN, `game_reset`=1, `start_tx`=0. Same pulse with `player_2_data_valid`=0 → stays MENU.
4. In PLAY, `boss_dead`=1 and `player_dead`=1 (single player) in the same cycle → END_DELAY, `win`=1. After 4 ticks `game_active`=2, `win` still 1.
5. Two-player PLAY, `player_dead`=1 only → stays PLAY. Then `player_2_dead`=1 → END_DELAY, `win`=0.
6. `game_start` during COUNTDOWN → no `game_reset`, state unchanged. `rst` pulse during END_DELAY → immediate `game_active`=0. `game_start` in OVER → COUNTDOWN with `game_reset` pulse and `win` cleared.
